// File: rtl/tpu_job_ctrl_if.sv
// tpu_job_ctrl_if: operand/result streams and TPU register bus of the job controller
interface tpu_job_ctrl_if #(parameter int DATAW = 64, parameter int ADDRW = 16);
  logic             src_valid;
  logic             src_ready;
  logic [DATAW-1:0] src_data;
  logic             res_valid;
  logic             res_ready;
  logic [DATAW-1:0] res_data;
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_dataIn;
  logic [DATAW-1:0] tpu_dataOut;
  modport master (
    input  src_valid, src_data, res_ready, tpu_dataOut,
    output src_ready, res_valid, res_data, tpu_r_w, tpu_addr, tpu_dataIn
  );
  modport slave (
    output src_valid, src_data, res_ready, tpu_dataOut,
    input  src_ready, res_valid, res_data, tpu_r_w, tpu_addr, tpu_dataIn
  );
endinterface

// File: rtl/tpu_job_ctrl.sv
// tpu_job_ctrl: loads A/B/C into the TPU, fires MatMul, waits, then streams C back out
module tpu_job_ctrl #(
  parameter int DIM         = 8,
  parameter int DATAW       = 64,
  parameter int ADDRW       = 16,
  parameter int WAIT_CYCLES = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           clear_c,
  output logic           busy,
  output logic           done,
  tpu_job_ctrl_if.master bus
);
  localparam int IW = $clog2(2 * DIM) > 0 ? $clog2(2 * DIM) : 1;
  localparam int CW = $clog2(WAIT_CYCLES + 2);
  typedef enum logic [3:0] {IDLE, LOAD_A, LOAD_B, LOAD_C, MATMUL, WAIT, READ, DRAIN, DONE} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             clr_q, clr_d;
  logic             r_w_q, r_w_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DATAW-1:0] din_q, din_d;
  logic             res_valid_q, res_valid_d;
  logic [DATAW-1:0] res_data_q, res_data_d;
  logic             src_rdy, xfer, last_row, last_c;
  logic [ADDRW-1:0] c_addr, c_addr_nxt;
  assign src_rdy    = state_q == LOAD_A || state_q == LOAD_B || (state_q == LOAD_C && !clr_q);
  assign xfer       = bus.src_valid && src_rdy;
  assign last_row   = idx_q == IW'(DIM - 1);
  assign last_c     = idx_q == IW'(2 * DIM - 1);
  // C rows are low/high pairs 8 bytes apart, so C word idx sits at 0x300 + 8*idx
  assign c_addr     = ADDRW'(16'h0300) + (ADDRW'(idx_q) << 3);
  assign c_addr_nxt = ADDRW'(16'h0308) + (ADDRW'(idx_q) << 3);
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    clr_d       = clr_q;
    r_w_d       = 1'b0;
    addr_d      = '0;
    din_d       = '0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD_A;
        clr_d   = clear_c;
        idx_d   = '0;
      end
      LOAD_A, LOAD_B: if (xfer) begin
        r_w_d   = 1'b1;
        addr_d  = (state_q == LOAD_A ? ADDRW'(16'h0100) : ADDRW'(16'h0200)) + (ADDRW'(idx_q) << 3);
        din_d   = bus.src_data;
        idx_d   = last_row ? '0 : idx_q + 1'b1;
        state_d = !last_row ? state_q : state_q == LOAD_A ? LOAD_B : LOAD_C;
      end
      LOAD_C: if (xfer || clr_q) begin
        r_w_d   = 1'b1;
        addr_d  = c_addr;
        din_d   = clr_q ? '0 : bus.src_data;
        idx_d   = last_c ? '0 : idx_q + 1'b1;
        state_d = last_c ? MATMUL : LOAD_C;
      end
      MATMUL: begin
        r_w_d   = 1'b1;
        addr_d  = ADDRW'(16'h0400);
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (cnt_q == CW'(WAIT_CYCLES)) begin
        addr_d  = ADDRW'(16'h0300);
        state_d = READ;
      end else cnt_d = cnt_q + 1'b1;
      READ: begin
        addr_d = addr_q;
        if (!res_valid_q || bus.res_ready) begin
          res_data_d  = bus.tpu_dataOut;
          res_valid_d = 1'b1;
          idx_d       = last_c ? '0 : idx_q + 1'b1;
          addr_d      = last_c ? '0 : c_addr_nxt;
          state_d     = last_c ? DRAIN : READ;
        end
      end
      DRAIN: if (bus.res_ready) begin
        res_valid_d = 1'b0;
        state_d     = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      clr_q       <= 1'b0;
      r_w_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      clr_q       <= clr_d;
      r_w_q       <= r_w_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  assign bus.src_ready  = src_rdy;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.tpu_r_w    = r_w_q;
  assign bus.tpu_addr   = addr_q;
  assign bus.tpu_dataIn = din_q;
  assign busy           = state_q != IDLE;
  assign done           = state_q == DONE;
endmodule

// File: doc/tpu_job_ctrl.md
TPU_JOB_CTRL -- requirements
Module: tpu_job_ctrl

Interface
REQ-001 SHALL have parameter DIM, default 8: systolic dimension; rows of A, B and C.
REQ-002 SHALL have parameter DATAW, default 64: bus and stream data width.
REQ-003 SHALL have parameter ADDRW, default 16: TPU bus address width.
REQ-004 SHALL have parameter WAIT_CYCLES, default 24: idle cycles after the MatMul write, before C readback.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-008 SHALL have port clear_c, input, 1 bit: sampled with start; 1 = controller writes zero C, 0 = C is taken from the stream.
REQ-009 SHALL have ports src_valid (input, 1), src_ready (output, 1) and src_data (input, DATAW): operand stream carrying A rows, then B rows, then C words.
REQ-010 SHALL have ports res_valid (output, 1), res_ready (input, 1) and res_data (output, DATAW): result stream.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at job completion.
REQ-013 SHALL have ports tpu_r_w (output, 1), tpu_addr (output, ADDRW), tpu_dataIn (output, DATAW) and tpu_dataOut (input, DATAW): TPU register bus.

Function
REQ-014 SHALL implement states IDLE, LOAD_A, LOAD_B, LOAD_C, MATMUL, WAIT, READ, DRAIN and DONE, with a word index idx of 0..2*DIM-1.
REQ-015 In IDLE, start=1 SHALL latch clear_c, clear idx and go to LOAD_A; start in any other state SHALL be ignored.
REQ-016 src_ready SHALL be 1 only in LOAD_A, LOAD_B, and in LOAD_C when the latched clear_c=0.
REQ-017 A stream transfer SHALL occur on a clock with src_valid and src_ready both 1; src_data is never consumed otherwise.
REQ-018 All tpu_* outputs SHALL be registered; each accepted word drives exactly one write cycle on the next clock (tpu_r_w=1, data=src_data).
REQ-019 Write addresses SHALL be: A row r = 0x0100+8r; B row r = 0x0200+8r; C row r low half = 0x0300+16r; C row r high half = 0x0308+16r.
REQ-020 C SHALL be written low then high for each row, rows 0..DIM-1 ascending (2*DIM writes).
REQ-021 With clear_c=1, LOAD_C SHALL issue the same 2*DIM writes on consecutive cycles with data 0, independent of src_valid.
REQ-022 Transitions: LOAD_A -> LOAD_B after DIM writes; LOAD_B -> LOAD_C after DIM writes; LOAD_C -> MATMUL after 2*DIM writes.
REQ-023 MATMUL SHALL issue exactly one write to 0x0400 with data 0, then go to WAIT.
REQ-024 WAIT SHALL drive idle bus cycles for exactly WAIT_CYCLES clocks, then enter READ with tpu_addr=0x0300.
REQ-025 An idle bus cycle SHALL drive tpu_r_w=0, tpu_addr=0x0000 and tpu_dataIn=0.
REQ-026 READ SHALL drive tpu_r_w=0 with tpu_addr equal to the C address for idx (same order as REQ-020), treating tpu_dataOut as combinational on the current address.
REQ-027 In READ, when res_valid=0 or res_ready=1, the block SHALL capture tpu_dataOut into res_data, set res_valid, and advance idx and tpu_addr; otherwise it SHALL hold all of them.
REQ-028 res_data SHALL remain stable while res_valid=1 and res_ready=0; res_valid SHALL clear on acceptance unless a new capture occurs on the same edge.
REQ-029 After the 2*DIM-th capture, the block SHALL go to DRAIN and drive idle bus cycles; on acceptance of the last word it SHALL go to DONE.
REQ-030 DONE SHALL assert done for one cycle, then return to IDLE; a start in DONE SHALL be ignored.
REQ-031 Stream stalls (src_valid=0) SHALL hold state and idx and produce idle bus cycles, with no timeout.

Reset
REQ-032 rst=1 SHALL at any time, including mid-job, force IDLE, idx=0, src_ready=0, res_valid=0, res_data=0, busy=0, done=0 and an idle bus (REQ-025), with no partial transaction issued.
REQ-033 After rst deasserts, the first start SHALL begin a fresh job from LOAD_A.

Verification
REQ-034 Full job, clear_c=0, src_valid always 1, res_ready always 1: 32 writes at 0x0100..0x0138, 0x0200..0x0238, 0x0300,0x0308,...,0x0378; then one write at 0x0400; then 24 idle cycles; then 16 reads in REQ-020 order; then done pulses once.
REQ-035 clear_c=1: exactly 16 operand words are consumed; the 16 C writes carry data 0 on back-to-back cycles.
REQ-036 src_valid toggling every other cycle: write order and addresses are unchanged, and no word is dropped or duplicated.
REQ-037 res_ready=0 for 5 cycles on result 3: res_data and tpu_addr hold and result 4 is not captured early; the 16 delivered values match the tpu_dataOut at each address.
REQ-038 rst pulse during WAIT, and a start during LOAD_B: after reset, outputs match REQ-032 and the next start replays REQ-034; the start during LOAD_B has no effect.
